// File: rtl/bsr_meta_arbiter.sv
// Arbitrates one single-port metadata SRAM among two read ports and a DMA write port.
// Optional stall counters are enabled with the BSR_META_ARB_PERF_EN macro.
module bsr_meta_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int RD_LAT       = 2,
  parameter int WR_BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              rd0_ren,
  input  logic [ADDR_W-1:0] rd0_raddr,
  output logic              rd0_gnt,
  output logic              rd0_rvalid,
  output logic [DATA_W-1:0] rd0_rdata,
  input  logic              rd1_ren,
  input  logic [ADDR_W-1:0] rd1_raddr,
  output logic              rd1_gnt,
  output logic              rd1_rvalid,
  output logic [DATA_W-1:0] rd1_rdata,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [31:0]       perf_stall0,
  output logic [31:0]       perf_stall1,
  output logic [31:0]       perf_wr_stall
);

  localparam int BC_W = $clog2(WR_BURST_MAX) + 1;
  localparam logic [BC_W-1:0] BC_MAX = BC_W'(WR_BURST_MAX);

  logic              any_ren;
  logic              wr_win;
  logic              rd_win;
  logic              rd_id;
  logic              rr_ptr;
  logic [BC_W-1:0]   burst_cnt;
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_id;

  // Gating with rst_n keeps the combinational command quiet while reset is held.
  always_comb begin
    any_ren = rd0_ren | rd1_ren;
    wr_win  = 1'b0;
    rd_win  = 1'b0;
    rd_id   = 1'b0;
    if (rst_n && !abort) begin
      if (wr_valid && ((burst_cnt < BC_MAX) || !any_ren)) begin
        wr_win = 1'b1;
      end else if (any_ren) begin
        rd_win = 1'b1;
        rd_id  = (rd0_ren && rd1_ren) ? rr_ptr : rd1_ren;
      end
    end
  end

  assign rd0_gnt    = rd_win & ~rd_id;
  assign rd1_gnt    = rd_win & rd_id;
  assign wr_ready   = wr_win;
  assign sram_en    = rd_win | wr_win;
  assign sram_we    = wr_win;
  assign sram_addr  = wr_win ? wr_addr : (rd_win ? (rd_id ? rd1_raddr : rd0_raddr) : '0);
  assign sram_wdata = wr_win ? wr_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= 1'b0;
      burst_cnt <= '0;
    end else begin
      if (rd_win) rr_ptr <= ~rd_id;
      if (abort || rd_win || !any_ren) begin
        burst_cnt <= '0;
      end else if (wr_win && (burst_cnt < BC_MAX)) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  generate
    if (RD_LAT == 1) begin : g_tag1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_v  <= '0;
          tag_id <= '0;
        end else begin
          tag_v[0]  <= rd_win & ~abort;
          tag_id[0] <= rd_id;
        end
      end
    end else begin : g_tagn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_v  <= '0;
          tag_id <= '0;
        end else begin
          tag_v  <= abort ? '0 : {tag_v[RD_LAT-2:0], rd_win};
          tag_id <= {tag_id[RD_LAT-2:0], rd_id};
        end
      end
    end
  endgenerate

  // A read landing in the abort cycle itself is also suppressed.
  assign rd0_rvalid = tag_v[RD_LAT-1] & ~tag_id[RD_LAT-1] & ~abort;
  assign rd1_rvalid = tag_v[RD_LAT-1] & tag_id[RD_LAT-1] & ~abort;
  assign rd0_rdata  = sram_rdata;
  assign rd1_rdata  = sram_rdata;

`ifdef BSR_META_ARB_PERF_EN
  logic [31:0] stall0_q;
  logic [31:0] stall1_q;
  logic [31:0] wr_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall0_q   <= '0;
      stall1_q   <= '0;
      wr_stall_q <= '0;
    end else begin
      if (rd0_ren && !rd0_gnt && (stall0_q != '1)) stall0_q <= stall0_q + 32'd1;
      if (rd1_ren && !rd1_gnt && (stall1_q != '1)) stall1_q <= stall1_q + 32'd1;
      if (wr_valid && !wr_ready && (wr_stall_q != '1)) wr_stall_q <= wr_stall_q + 32'd1;
    end
  end

  assign perf_stall0   = stall0_q;
  assign perf_stall1   = stall1_q;
  assign perf_wr_stall = wr_stall_q;
`else
  assign perf_stall0   = '0;
  assign perf_stall1   = '0;
  assign perf_wr_stall = '0;
`endif

endmodule
